// File: rtl/sig_align_pipe.sv
// Two-stage significand aligner: stage 1 shifts each lane's hidden-one significand, stage 2 emits two signed copies.
// Define SIG_ALIGN_STICKY_EN to build the per-lane sticky bit; otherwise sticky is tied to zero.
module sig_align_pipe #(
    parameter int EXP_WIDTH  = 4,
    parameter int SIG_WIDTH  = 4,
    parameter int LOW_EXPAND = 2,
    parameter int LANES      = 4,
    localparam int W         = SIG_WIDTH + 4 + LOW_EXPAND
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_WIDTH*LANES-1:0] exp_offset_num,
    input  logic [SIG_WIDTH*LANES-1:0] significand,
    input  logic [LANES-1:0]           sign,
    input  logic [LANES-1:0]           complement_sign1,
    input  logic [LANES-1:0]           complement_sign2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W*LANES-1:0]         adder_num1,
    output logic [W*LANES-1:0]         adder_num2,
    output logic [LANES-1:0]           sticky
);

    localparam int MW = W - 1;

    logic                      v1_q, v1_d, v2_q, v2_d;
    logic                      ld1, ld2, accept;
    logic [LANES-1:0][MW-1:0]  a_q, a_d;
    logic [LANES-1:0]          zero_q, zero_d;
    logic [LANES-1:0]          neg1_q, neg1_d, neg2_q, neg2_d;
    logic [LANES-1:0][W-1:0]   num1_q, num1_d, num2_q, num2_d;
    logic [MW-1:0]             m_l, sh_l;
    logic [EXP_WIDTH-1:0]      off_l;
`ifdef SIG_ALIGN_STICKY_EN
    logic [LANES-1:0]          st_q, st_d, sticky_q, sticky_d;
`endif

    // Zero lanes must stay zero regardless of neg, so the -0 case never sets the sign bit.
    function automatic logic [W-1:0] signed_copy(input logic neg, input logic zero,
                                                 input logic [MW-1:0] a);
        logic [MW-1:0] t;
        t = neg ? (~a + 1'b1) : a;
        return zero ? '0 : {neg, t};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        ld2      = !v2_q || out_ready;
        ld1      = !v1_q || ld2;
        in_ready = ld1 && !flush;
        accept   = in_valid && in_ready;

        v1_d = flush ? 1'b0 : (ld1 ? accept : v1_q);
        v2_d = flush ? 1'b0 : (ld2 ? v1_q : v2_q);

        a_d    = a_q;
        zero_d = zero_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        num1_d = num1_q;
        num2_d = num2_q;
        m_l    = '0;
        sh_l   = '0;
        off_l  = '0;
`ifdef SIG_ALIGN_STICKY_EN
        st_d     = st_q;
        sticky_d = sticky_q;
`endif

        for (int i = 0; i < LANES; i++) begin
            off_l = exp_offset_num[EXP_WIDTH*i +: EXP_WIDTH];
            m_l   = {3'b001, significand[SIG_WIDTH*i +: SIG_WIDTH], {LOW_EXPAND{1'b0}}};
            sh_l  = m_l >> off_l;
            if (accept) begin
                a_d[i]    = sh_l;
                zero_d[i] = (sh_l == '0);
                neg1_d[i] = sign[i] ^ complement_sign1[i];
                neg2_d[i] = sign[i] ^ complement_sign2[i];
`ifdef SIG_ALIGN_STICKY_EN
                // Shifts of W-1 or more leave an all-ones mask; the hidden one then forces sticky high.
                st_d[i] = |(m_l & ~({MW{1'b1}} << off_l));
`endif
            end
            if (ld2 && v1_q) begin
                num1_d[i] = signed_copy(neg1_q[i], zero_q[i], a_q[i]);
                num2_d[i] = signed_copy(neg2_q[i], zero_q[i], a_q[i]);
`ifdef SIG_ALIGN_STICKY_EN
                sticky_d[i] = st_q[i];
`endif
            end
        end
    end

    // NOTE: data registers are reset as well, so outputs read zero immediately on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            a_q      <= '0;
            zero_q   <= '0;
            neg1_q   <= '0;
            neg2_q   <= '0;
            num1_q   <= '0;
            num2_q   <= '0;
`ifdef SIG_ALIGN_STICKY_EN
            st_q     <= '0;
            sticky_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            a_q      <= a_d;
            zero_q   <= zero_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
`ifdef SIG_ALIGN_STICKY_EN
            st_q     <= st_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    assign out_valid  = v2_q;
    assign adder_num1 = num1_q;
    assign adder_num2 = num2_q;
`ifdef SIG_ALIGN_STICKY_EN
    assign sticky     = sticky_q;
`else
    assign sticky     = '0;
`endif

endmodule

// File: tb/tb_sig_align_pipe.sv
// Directed bench for sig_align_pipe: an arithmetic reference model feeds a scoreboard checked at every output beat.
module tb_sig_align_pipe;
    localparam int EW = 4;
    localparam int SW = 4;
    localparam int LE = 2;
    localparam int L  = 4;
    localparam int W  = SW + 4 + LE;
`ifdef SIG_ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic              clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [EW*L-1:0]   exp_offset_num;
    logic [SW*L-1:0]   significand;
    logic [L-1:0]      sign, complement_sign1, complement_sign2, sticky;
    logic [W*L-1:0]    adder_num1, adder_num2;

    typedef struct {
        logic [W*L-1:0] n1;
        logic [W*L-1:0] n2;
        logic [L-1:0]   st;
    } beat_t;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    sig_align_pipe #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .LOW_EXPAND(LE), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .exp_offset_num(exp_offset_num), .significand(significand), .sign(sign),
        .complement_sign1(complement_sign1), .complement_sign2(complement_sign2),
        .out_valid(out_valid), .out_ready(out_ready),
        .adder_num1(adder_num1), .adder_num2(adder_num2), .sticky(sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Plain integer arithmetic: value = (hidden one + sig) scaled by the guard bits, shifted, then negated.
    function automatic beat_t model(input logic [EW*L-1:0] off, input logic [SW*L-1:0] sig,
                                    input logic [L-1:0] s, input logic [L-1:0] c1,
                                    input logic [L-1:0] c2);
        beat_t b;
        int m, a, o, v;
        b.n1 = '0;
        b.n2 = '0;
        b.st = '0;
        for (int i = 0; i < L; i++) begin
            o = int'(off[EW*i +: EW]);
            m = ((1 << SW) + int'(sig[SW*i +: SW])) << LE;
            a = m >> o;
            v = (s[i] ^ c1[i]) ? -a : a;
            b.n1[W*i +: W] = v[W-1:0];
            v = (s[i] ^ c2[i]) ? -a : a;
            b.n2[W*i +: W] = v[W-1:0];
            b.st[i] = STK && ((m & ((1 << o) - 1)) != 0);
        end
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_occupancy", 64'(sb.size()), 64'd1);
                end else begin
                    check("sb_num1", 64'(adder_num1), 64'(sb[0].n1));
                    check("sb_num2", 64'(adder_num2), 64'(sb[0].n2));
                    check("sb_sticky", 64'(sticky), 64'(sb[0].st));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(exp_offset_num, significand, sign,
                                   complement_sign1, complement_sign2));
            if (flush) sb.delete();
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [EW*L-1:0] off, input logic [SW*L-1:0] sig,
                        input logic [L-1:0] s, input logic [L-1:0] c1, input logic [L-1:0] c2);
        bit acc;
        int n;
        exp_offset_num   = off;
        significand      = sig;
        sign             = s;
        complement_sign1 = c1;
        complement_sign2 = c2;
        in_valid         = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic check_lane0(input string tag, input logic [W-1:0] n1, input logic [W-1:0] n2,
                               input logic st);
        check({tag, "_num1"}, 64'(adder_num1[W-1:0]), 64'(n1));
        check({tag, "_num2"}, 64'(adder_num2[W-1:0]), 64'(n2));
        check({tag, "_sticky"}, 64'(sticky[0]), 64'(st));
    endtask

    task automatic check_latency(input string tag);
        @(negedge clk);
        check({tag, "_cycle1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_cycle2"}, 64'(out_valid), 64'd1);
    endtask

    function automatic logic [EW*L-1:0] rnd_off(input logic [EW-1:0] lane0);
        logic [EW*L-1:0] r;
        r = EW*L'($urandom);
        r[EW-1:0] = lane0;
        return r;
    endfunction

    function automatic logic [SW*L-1:0] rnd_sig(input logic [SW-1:0] lane0);
        logic [SW*L-1:0] r;
        r = SW*L'($urandom);
        r[SW-1:0] = lane0;
        return r;
    endfunction

    function automatic logic [L-1:0] rnd_bits(input logic lane0);
        logic [L-1:0] r;
        r = L'($urandom);
        r[0] = lane0;
        return r;
    endfunction

    initial begin
        rst_n            = 1'b0;
        flush            = 1'b0;
        in_valid         = 1'b0;
        out_ready        = 1'b1;
        exp_offset_num   = '0;
        significand      = '0;
        sign             = '0;
        complement_sign1 = '0;
        complement_sign2 = '0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_num1", 64'(adder_num1), 64'd0);
        check("rst_num2", 64'(adder_num2), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sync();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic align: 26 and -26 in lane 0, two-cycle latency
        send(rnd_off(4'd2), rnd_sig(4'b1010), rnd_bits(1'b0), rnd_bits(1'b0), rnd_bits(1'b1));
        check_latency("lat_basic");
        check_lane0("basic", 10'h01A, 10'h3E6, 1'b0);
        sync();

        // Zero shift, then full shift-out of a negative operand
        send(rnd_off(4'd0), rnd_sig(4'b1010), rnd_bits(1'b0), rnd_bits(1'b0), rnd_bits(1'b0));
        wait_out();
        check_lane0("shift0", 10'h068, 10'h068, 1'b0);
        sync();
        send(rnd_off(4'd9), rnd_sig(4'b1010), rnd_bits(1'b1), rnd_bits(1'b0), rnd_bits(1'b0));
        wait_out();
        check_lane0("shift9", 10'h000, 10'h000, STK);
        sync();

        // Sticky boundary
        send(rnd_off(4'd3), rnd_sig(4'b1010), rnd_bits(1'b0), rnd_bits(1'b0), rnd_bits(1'b0));
        wait_out();
        check_lane0("shift3", 10'd13, 10'd13, 1'b0);
        sync();
        send(rnd_off(4'd4), rnd_sig(4'b1010), rnd_bits(1'b0), rnd_bits(1'b0), rnd_bits(1'b0));
        wait_out();
        check_lane0("shift4", 10'd6, 10'd6, STK);
        sync();

        // Backpressure: four beats against a three-cycle stall
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(rnd_off(4'($urandom)), rnd_sig(4'($urandom)), rnd_bits(1'($urandom)),
                         rnd_bits(1'($urandom)), rnd_bits(1'($urandom)));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check("bp_in_ready_after2", 64'(in_ready), 64'd0);
                sync();
                check("bp_in_ready_held", 64'(in_ready), 64'd0);
                check("bp_out_valid_held", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_full_pushpop", 64'(in_ready), 64'd1);
            end
        join
        repeat (4) sync();
        check("bp_drain", 64'(sb.size()), 64'd0);

        // Flush with both stages full and a beat offered
        out_ready = 1'b0;
        send(rnd_off(4'd1), rnd_sig(4'd5), '0, '0, '0);
        send(rnd_off(4'd2), rnd_sig(4'd6), '0, '0, '0);
        exp_offset_num = rnd_off(4'd1);
        significand    = rnd_sig(4'd7);
        in_valid       = 1'b1;
        flush          = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        check("fl_pre_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fl_out_valid", 64'(out_valid), 64'd0);
        end
        sync();
        out_ready = 1'b1;

        // Asynchronous reset while a beat is stalled at the output
        out_ready = 1'b0;
        send(16'h4444, rnd_sig(4'($urandom)), rnd_bits(1'b1), rnd_bits(1'b0), rnd_bits(1'b1));
        wait_out();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_num1", 64'(adder_num1), 64'd0);
        check("arst_num2", 64'(adder_num2), 64'd0);
        check("arst_sticky", 64'(sticky), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sync();
        out_ready = 1'b1;
        send(rnd_off(4'd1), rnd_sig(4'b0011), rnd_bits(1'b1), rnd_bits(1'b0), rnd_bits(1'b1));
        check_latency("lat_post_reset");
        sync();

        repeat (5) sync();
        check("final_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
